// File: rtl/if_prefetch_queue_if.sv
// Bundle of the instruction-memory fetch port and the decode-side queue port
// for if_prefetch_queue; master is the queue, slave is memory plus decode.
interface if_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ack_i;
    logic [31:0]   imem_data_i;
    logic          deq_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_next_o;
    logic [CW-1:0] count_o;

    modport master (
        output imem_req_o, imem_addr_o, valid_o, instr_o, pc_next_o, count_o,
        input  imem_ack_i, imem_data_i, deq_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_next_o, count_o,
        output imem_ack_i, imem_data_i, deq_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: one outstanding fetch at a time, DEPTH-entry FIFO
// towards decode, redirect flush. Define IFQ_BYPASS_EN for same-cycle ack bypass.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input logic                  clk_i,
    input logic                  rst_i,
    if_prefetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_inc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_post;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pcn   [DEPTH];

    logic ack_wait;
    logic has_head;
    logic bypass_hit;
    logic push;
    logic pop;

    assign fetch_pc_inc = fetch_pc + 32'd4;
    assign ack_wait     = (state == WAIT) && bus.imem_ack_i;
    assign has_head     = (count != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = ack_wait && !has_head && !bus.redirect_i;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word consumed by decode in the same cycle never enters the FIFO.
    assign pop  = bus.deq_i && has_head && !bus.redirect_i;
    assign push = ack_wait && !bus.redirect_i && !(bypass_hit && bus.deq_i);

    always_comb begin
        count_post = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.redirect_i && (count < CW'(DEPTH))) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_i) begin
                    state_nxt = bus.imem_ack_i ? IDLE : DISCARD;
                end else if (bus.imem_ack_i) begin
                    state_nxt = (count_post < CW'(DEPTH)) ? WAIT : IDLE;
                end
            end
            DISCARD: begin
                if (bus.imem_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect_i) begin
            fetch_pc <= bus.redirect_pc_i;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (ack_wait) begin
                fetch_pc <= fetch_pc_inc;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count_post;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr[tail] <= bus.imem_data_i;
            mem_pcn[tail]   <= fetch_pc_inc;
        end
    end

    always_comb begin
        bus.imem_req_o  = (state != IDLE);
        bus.imem_addr_o = fetch_pc;
        bus.count_o     = count;
        bus.valid_o     = has_head || bypass_hit;
        bus.instr_o     = '0;
        bus.pc_next_o   = '0;
        if (has_head) begin
            bus.instr_o   = mem_instr[head];
            bus.pc_next_o = mem_pcn[head];
        end else if (bypass_hit) begin
            bus.instr_o   = bus.imem_data_i;
            bus.pc_next_o = fetch_pc_inc;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_if_prefetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: outstanding request flag, drop flag, fetch address, FIFO contents.
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_pc;
    ent_t        q[$];
    logic [31:0] acked[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_pc   = RPC;
        q.delete();
    endfunction

    task automatic compare_model();
        bit          byp;
        logic [31:0] e_instr;
        logic [31:0] e_pcn;
        byp = BYP && m_out && !m_drop && bus.imem_ack_i && (q.size() == 0) && !bus.redirect_i;
        e_instr = 32'h0;
        e_pcn   = 32'h0;
        if (q.size() > 0) begin
            e_instr = q[0].instr;
            e_pcn   = q[0].pc + 32'd4;
        end else if (byp) begin
            e_instr = bus.imem_data_i;
            e_pcn   = m_pc + 32'd4;
        end
        chk("model_req",   {31'b0, bus.imem_req_o}, {31'b0, m_out});
        chk("model_addr",  bus.imem_addr_o, m_pc);
        chk("model_count", 32'(bus.count_o), 32'(q.size()));
        chk("model_valid", {31'b0, bus.valid_o}, {31'b0, (q.size() > 0) || byp});
        chk("model_instr", bus.instr_o, e_instr);
        chk("model_pcnext", bus.pc_next_o, e_pcn);
    endtask

    function automatic void model_update();
        bit          d;
        bit          a;
        int          pre;
        bit          byp;
        d   = bus.deq_i;
        a   = bus.imem_ack_i;
        pre = q.size();
        if (bus.redirect_i) begin
            q.delete();
            m_pc = bus.redirect_pc_i;
            if (m_out && a) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else if (m_out && a && m_drop) begin
            m_out  = 1'b0;
            m_drop = 1'b0;
            if (d && pre > 0) void'(q.pop_front());
        end else if (m_out && a) begin
            byp = BYP && (pre == 0);
            acked.push_back(m_pc);
            if (!(byp && d)) begin
                if (d && pre > 0) void'(q.pop_front());
                q.push_back('{instr: bus.imem_data_i, pc: m_pc});
            end
            m_pc  = m_pc + 32'd4;
            m_out = (q.size() < DEPTH);
        end else begin
            if (d && pre > 0) void'(q.pop_front());
            if (!m_out && pre < DEPTH) m_out = 1'b1;
        end
    endfunction

    task automatic clear_inputs();
        bus.deq_i         = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.imem_ack_i    = 1'b0;
        bus.imem_data_i   = 32'h0;
    endtask

    // Called at a negedge; memory never acks unless a request is expected.
    task automatic drive(input bit d, input bit r, input logic [31:0] rp,
                         input bit a, input logic [31:0] dat);
        bus.deq_i         = d;
        bus.redirect_i    = r;
        bus.redirect_pc_i = rp;
        bus.imem_ack_i    = a && m_out;
        bus.imem_data_i   = dat;
        #1;
        compare_model();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        clear_inputs();
        #1;
    endtask

    task automatic cycle(input bit d, input bit r, input logic [31:0] rp,
                         input bit a, input logic [31:0] dat);
        drive(d, r, rp, a, dat);
        step();
    endtask

    logic [31:0] prev_pcn;

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #3;
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rst_req",   {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst_addr",  bus.imem_addr_o, 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_pcnext", bus.pc_next_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_req", {31'b0, bus.imem_req_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // First request rises on the first edge after reset release.
        cycle(0, 0, 32'h0, 0, 32'h0);
        chk("first_req",  {31'b0, bus.imem_req_o}, 32'd1);
        chk("first_addr", bus.imem_addr_o, 32'h0);

        // Fill with ack every cycle, no dequeue.
        acked.delete();
        for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0, 1, 32'hC0DE0000 | m_pc);
        chk("fill_nacks", 32'(acked.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("fill_addr", acked[i], 32'(i * 4));
        chk("fill_count",  32'(bus.count_o), 32'd4);
        chk("fill_req",    {31'b0, bus.imem_req_o}, 32'd0);
        chk("fill_valid",  {31'b0, bus.valid_o}, 32'd1);
        chk("fill_pcnext", bus.pc_next_o, 32'd4);
        chk("fill_instr",  bus.instr_o, 32'hC0DE0000);

        // One dequeue from full reopens fetching at address 16.
        cycle(1, 0, 32'h0, 0, 32'h0);
        chk("deq_count", 32'(bus.count_o), 32'd3);
        chk("deq_req",   {31'b0, bus.imem_req_o}, 32'd0);
        cycle(0, 0, 32'h0, 0, 32'h0);
        chk("refetch_req",  {31'b0, bus.imem_req_o}, 32'd1);
        chk("refetch_addr", bus.imem_addr_o, 32'd16);

        // Redirect in the first wait cycle, stale ack three cycles in.
        cycle(0, 1, 32'h100, 0, 32'h0);
        chk("disc_count", 32'(bus.count_o), 32'd0);
        chk("disc_req",   {31'b0, bus.imem_req_o}, 32'd1);
        chk("disc_addr",  bus.imem_addr_o, 32'h100);
        cycle(0, 0, 32'h0, 0, 32'h0);
        cycle(0, 0, 32'h0, 1, 32'hDEADBEEF);
        chk("drop_count", 32'(bus.count_o), 32'd0);
        chk("drop_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("drop_req",   {31'b0, bus.imem_req_o}, 32'd0);
        cycle(0, 0, 32'h0, 0, 32'h0);
        chk("redir_addr", bus.imem_addr_o, 32'h100);
        chk("redir_req",  {31'b0, bus.imem_req_o}, 32'd1);

        // Redirect coinciding with ack while two entries are queued.
        cycle(0, 0, 32'h0, 1, 32'h11111111);
        cycle(0, 0, 32'h0, 1, 32'h22222222);
        chk("two_count", 32'(bus.count_o), 32'd2);
        cycle(0, 1, 32'h2000, 1, 32'h33333333);
        chk("rack_count", 32'(bus.count_o), 32'd0);
        chk("rack_valid", {31'b0, bus.valid_o}, 32'd0);
        chk("rack_req",   {31'b0, bus.imem_req_o}, 32'd0);
        cycle(0, 0, 32'h0, 0, 32'h0);
        chk("rack_addr", bus.imem_addr_o, 32'h2000);

        // Streaming: ack and dequeue together keep occupancy flat.
        cycle(0, 0, 32'h0, 1, 32'hAAAA0000);
        prev_pcn = bus.pc_next_o;
        chk("stream_first_pcn", prev_pcn, 32'h2004);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 32'h0, 1, 32'hAAAA0000 + 32'(i));
            chk("stream_count", 32'(bus.count_o), 32'd1);
            chk("stream_pcn", bus.pc_next_o, prev_pcn + 32'd4);
            prev_pcn = bus.pc_next_o;
        end

        // Ack into an empty queue with decode consuming in the same cycle.
        cycle(1, 0, 32'h0, 0, 32'h0);
        chk("empty_count", 32'(bus.count_o), 32'd0);
        drive(1, 0, 32'h0, 1, 32'h8C220004);
        chk("byp_valid", {31'b0, bus.valid_o}, {31'b0, BYP});
        chk("byp_instr", bus.instr_o, BYP ? 32'h8C220004 : 32'h0);
        step();
        chk("byp_count", 32'(bus.count_o), BYP ? 32'd0 : 32'd1);

        // Reset in the middle of an outstanding request.
        bus.deq_i = 1'b0;
        #1;
        chk("pre_rst_req", {31'b0, bus.imem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_req",   {31'b0, bus.imem_req_o}, 32'd0);
        chk("mid_rst_count", 32'(bus.count_o), 32'd0);
        chk("mid_rst_addr",  bus.imem_addr_o, RPC);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 2) != 0,
                  $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'd0, first fetch address after reset.
REQ-003 clk_i  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 imem_req_o  output  1  instruction-memory read request.
REQ-006 imem_addr_o  output  32  request word address.
REQ-007 imem_ack_i  input  1  memory completion; imem_data_i valid this cycle.
REQ-008 imem_data_i  input  32  fetched instruction.
REQ-009 deq_i  input  1  decode stage consumes head entry (IF/ID write enable).
REQ-010 redirect_i  input  1  taken-branch flush from the MEM stage.
REQ-011 redirect_pc_i  input  32  branch target.
REQ-012 valid_o  output  1  head entry present.
REQ-013 instr_o  output  32  head instruction.
REQ-014 pc_next_o  output  32  head fetch address + 4.
REQ-015 count_o  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-016 FSM states SHALL be IDLE (no request), WAIT (request outstanding) and DISCARD (outstanding request whose data is dropped).
REQ-017 imem_req_o SHALL be 1 exactly in WAIT and DISCARD; imem_addr_o SHALL hold fetch_pc stable until ack.
REQ-018 IDLE->WAIT when count_o < DEPTH and redirect_i=0.
REQ-019 WAIT with ack: entry {imem_data_i, fetch_pc} written at tail; fetch_pc += 4 (mod 2^32); next state WAIT if post-update count < DEPTH, else IDLE (back-to-back fetch, one outstanding request max).
REQ-020 Never more than one outstanding request; no write when full is possible by construction; the bench SHALL flag any ack while IDLE as an error.
REQ-021 deq_i with valid_o=1 SHALL pop the head; deq_i with valid_o=0 SHALL be ignored.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count_o unchanged.
REQ-023 redirect_i SHALL, at that edge, empty the queue (count_o=0), set fetch_pc=redirect_pc_i, and ignore deq_i.
REQ-024 Redirect in WAIT without ack -> DISCARD; with ack in the same cycle -> data dropped, next state IDLE.
REQ-025 DISCARD on ack -> IDLE, data dropped; a further redirect in DISCARD SHALL only update fetch_pc.
REQ-026 Head/tail pointers SHALL wrap modulo DEPTH.
REQ-027 Base latency: ack at edge N -> valid_o=1 after edge N.

Reset
REQ-028 While rst_i=1: state IDLE, count_o=0, valid_o=0, imem_req_o=0, fetch_pc=imem_addr_o=RESET_PC, pointers 0.
REQ-029 instr_o and pc_next_o SHALL be 0 while valid_o=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; the bench SHALL not ack after reset.
REQ-031 The first request SHALL assert on the first edge after rst_i deasserts.

Configuration
REQ-032 Macro IFQ_BYPASS_EN: when defined, an ack arriving with an empty queue and no redirect SHALL drive valid_o, instr_o and pc_next_o combinationally in the same cycle.
REQ-033 Under IFQ_BYPASS_EN, if deq_i=1 in that cycle, the entry SHALL NOT be written.
REQ-034 Without IFQ_BYPASS_EN, REQ-027 latency applies unconditionally.

Verification
REQ-035 Reset, ack every cycle, deq_i=0, DEPTH=4 -> addrs 0,4,8,12 requested; count_o reaches 4; req drops; valid_o=1 with pc_next_o=4.
REQ-036 Full queue, deq_i=1 for one cycle -> count_o 3, request for addr 16 reissued next cycle.
REQ-037 Ack latency 3 cycles, redirect_i=1 with redirect_pc_i=0x100 in first wait cycle -> DISCARD, stale data dropped, next request addr 0x100, count_o=0.
REQ-038 Redirect and ack same cycle with queue holding 2 entries -> count_o=0, valid_o=0, next addr=redirect_pc_i.
REQ-039 Continuous ack and deq_i=1 for 10 cycles -> count_o constant, pc_next_o increments by 4 per cycle, pointers wrap.
REQ-040 IFQ_BYPASS_EN, empty queue, ack with data 0x8C220004 and deq_i=1 -> instr_o=0x8C220004 and valid_o=1 that cycle, count_o stays 0.
